// File: rtl/xem5010_mem_pkg.sv
// Command codes, burst size, error bit positions and shared types for the XEM5010 memory responder.
package xem5010_mem_pkg;
    localparam logic [2:0] CMD_WRITE   = 3'b000;
    localparam logic [2:0] CMD_READ    = 3'b001;
    localparam int         BURST_BEATS = 2;
    localparam int         ERR_AF_OVF  = 0;
    localparam int         ERR_WDF_OVF = 1;
    localparam int         ERR_ILL_CMD = 2;

    typedef enum logic [2:0] {ST_IDLE, ST_WR0, ST_WR1, ST_RD0, ST_RD1} state_e;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [30:0] addr;
    } af_entry_t;

    // Column address is in 16-bit units, so a 32-bit word index is addr/2 plus the beat number.
    function automatic logic [30:0] word_idx(input logic [30:0] addr, input logic k);
        return (addr >> 1) + 31'(k);
    endfunction
endpackage

// File: rtl/xem5010_mem_responder_if.sv
// App-side bus of the DDR2 controller stand-in: command/write-data pushes, read beats, status.
interface xem5010_mem_responder_if;
    logic        s_phy_init_done;
    logic        s_app_af_wren;
    logic [2:0]  s_app_af_cmd;
    logic [30:0] s_app_af_addr;
    logic        s_app_af_afull;
    logic        s_app_wdf_wren;
    logic [31:0] s_app_wdf_data;
    logic [3:0]  s_app_wdf_mask_data;
    logic        s_app_wdf_afull;
    logic        s_app_rd_data_valid;
    logic [31:0] s_app_rd_data;
    logic [2:0]  s_err;

    modport master (
        output s_app_af_wren, s_app_af_cmd, s_app_af_addr,
               s_app_wdf_wren, s_app_wdf_data, s_app_wdf_mask_data,
        input  s_phy_init_done, s_app_af_afull, s_app_wdf_afull,
               s_app_rd_data_valid, s_app_rd_data, s_err
    );
    modport slave (
        input  s_app_af_wren, s_app_af_cmd, s_app_af_addr,
               s_app_wdf_wren, s_app_wdf_data, s_app_wdf_mask_data,
        output s_phy_init_done, s_app_af_afull, s_app_wdf_afull,
               s_app_rd_data_valid, s_app_rd_data, s_err
    );
endinterface

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered almost-full and an overflow strobe.
module fifo_sync #(
    parameter int W            = 8,
    parameter int AW           = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          afull,
    output logic          ovf
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          afull_q, full, do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !do_pop;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout    = mem_q[rptr_q];
    assign count   = cnt_q;
    assign afull   = afull_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            afull_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            afull_q <= ((AW+1)'(DEPTH) - cnt_d) <= (AW+1)'(AFULL_MARGIN);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/xem5010_mem_rd_pipe.sv
// Fixed-latency valid/data shift register carrying read beats to the app interface.
module xem5010_mem_rd_pipe #(
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_i,
    input  logic [31:0] data_i,
    output logic        vld_o,
    output logic [31:0] data_o
);
    logic [STAGES:0]       vld_pipe;
    logic [STAGES:0][31:0] data_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            for (int i = STAGES; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
            vld_pipe[0]  <= vld_i;
            data_pipe[0] <= vld_i ? data_i : '0;
        end
    end

    assign vld_o  = vld_pipe[STAGES];
    assign data_o = data_pipe[STAGES];
endmodule

// File: rtl/xem5010_mem_responder.sv
// Emulated DDR2 app interface: command/write-data FIFOs, burst FSM, on-chip RAM, fixed-latency reads.
// Define MEM_RESP_MASK_EN to store the write byte mask and honour it on RAM writes.
module xem5010_mem_responder
    import xem5010_mem_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int AF_ADDR_WIDTH  = 4,
    parameter int WDF_ADDR_WIDTH = 5,
    parameter int AFULL_MARGIN   = 4,
    parameter int RD_LATENCY     = 6,
    parameter int INIT_CYCLES    = 64
) (
    input logic                    s_clk,
    input logic                    s_rst,
    xem5010_mem_responder_if.slave bus
);
`ifdef MEM_RESP_MASK_EN
    localparam int WDF_W = 36;
`else
    localparam int WDF_W = 32;
`endif
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    state_e                    state_q;
    logic                      init_done_q;
    logic [INIT_W-1:0]         init_cnt_q;
    logic [2:0]                err_q;
    logic                      rd_vld_q;
    logic [31:0]               rd_word_q;
    logic [31:0]               ram_q [2**MEM_ADDR_WIDTH];

    af_entry_t                 af_din, af_head;
    logic [AF_ADDR_WIDTH:0]    af_count;
    logic                      af_pop, af_afull, af_ovf;
    logic [WDF_W-1:0]          wdf_din, wdf_head;
    logic [WDF_ADDR_WIDTH:0]   wdf_count;
    logic                      wdf_pop, wdf_afull, wdf_ovf;
    logic                      head_vld, ill_cmd, ram_we, ram_re, beat1;
    logic [MEM_ADDR_WIDTH-1:0] ram_idx;

    assign af_din  = '{cmd: bus.s_app_af_cmd, addr: bus.s_app_af_addr};
`ifdef MEM_RESP_MASK_EN
    assign wdf_din = {bus.s_app_wdf_mask_data, bus.s_app_wdf_data};
`else
    assign wdf_din = bus.s_app_wdf_data;
`endif

    fifo_sync #(.W($bits(af_entry_t)), .AW(AF_ADDR_WIDTH), .AFULL_MARGIN(AFULL_MARGIN)) u_af (
        .clk(s_clk), .rst(s_rst), .push(bus.s_app_af_wren && init_done_q), .din(af_din),
        .pop(af_pop), .dout(af_head), .count(af_count), .afull(af_afull), .ovf(af_ovf)
    );

    fifo_sync #(.W(WDF_W), .AW(WDF_ADDR_WIDTH), .AFULL_MARGIN(AFULL_MARGIN)) u_wdf (
        .clk(s_clk), .rst(s_rst), .push(bus.s_app_wdf_wren && init_done_q), .din(wdf_din),
        .pop(wdf_pop), .dout(wdf_head), .count(wdf_count), .afull(wdf_afull), .ovf(wdf_ovf)
    );

    assign head_vld = af_count != '0;
    assign ill_cmd  = (state_q == ST_IDLE) && head_vld &&
                      (af_head.cmd != CMD_WRITE) && (af_head.cmd != CMD_READ);
    assign ram_we   = (state_q == ST_WR0) || (state_q == ST_WR1);
    assign ram_re   = (state_q == ST_RD0) || (state_q == ST_RD1);
    assign beat1    = (state_q == ST_WR1) || (state_q == ST_RD1);
    assign wdf_pop  = ram_we;
    assign af_pop   = beat1 || ill_cmd;
    assign ram_idx  = MEM_ADDR_WIDTH'(word_idx(af_head.addr, beat1));

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b0;
            init_cnt_q  <= '0;
            err_q       <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            if (!init_done_q) begin
                init_cnt_q  <= init_cnt_q + 1'b1;
                init_done_q <= init_cnt_q == INIT_W'(INIT_CYCLES - 1);
            end
            err_q[ERR_AF_OVF]  <= err_q[ERR_AF_OVF]  | af_ovf;
            err_q[ERR_WDF_OVF] <= err_q[ERR_WDF_OVF] | wdf_ovf;
            err_q[ERR_ILL_CMD] <= err_q[ERR_ILL_CMD] | ill_cmd;
            rd_vld_q <= ram_re;
            case (state_q)
                // A write waits at the head until both of its beats are queued.
                ST_IDLE: if (head_vld) begin
                    if (af_head.cmd == CMD_READ)
                        state_q <= ST_RD0;
                    else if (af_head.cmd == CMD_WRITE &&
                             wdf_count >= (WDF_ADDR_WIDTH+1)'(BURST_BEATS))
                        state_q <= ST_WR0;
                end
                ST_WR0:  state_q <= ST_WR1;
                ST_WR1:  state_q <= ST_IDLE;
                ST_RD0:  state_q <= ST_RD1;
                ST_RD1:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (ram_we) begin
`ifdef MEM_RESP_MASK_EN
            for (int b = 0; b < 4; b++)
                if (!wdf_head[32+b]) ram_q[ram_idx][8*b +: 8] <= wdf_head[8*b +: 8];
`else
            ram_q[ram_idx] <= wdf_head;
`endif
        end
        if (ram_re) rd_word_q <= ram_q[ram_idx];
    end

    // The RAM read register is the first cycle of latency; the pipe supplies the rest.
    xem5010_mem_rd_pipe #(.STAGES(RD_LATENCY - 2)) u_rd_pipe (
        .clk(s_clk), .rst(s_rst), .vld_i(rd_vld_q), .data_i(rd_word_q),
        .vld_o(bus.s_app_rd_data_valid), .data_o(bus.s_app_rd_data)
    );

    assign bus.s_phy_init_done = init_done_q;
    assign bus.s_app_af_afull  = af_afull;
    assign bus.s_app_wdf_afull = wdf_afull;
    assign bus.s_err           = err_q;
endmodule

// File: tb/tb_xem5010_mem_responder.sv
// Bench for xem5010_mem_responder: vector table, directed corner sequences, random traffic vs a word-array model.
module tb_xem5010_mem_responder;
    import xem5010_mem_pkg::*;

    localparam int RDL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xem5010_mem_responder_if ifc();

    xem5010_mem_responder #(
        .MEM_ADDR_WIDTH(10), .AF_ADDR_WIDTH(4), .WDF_ADDR_WIDTH(5),
        .AFULL_MARGIN(4), .RD_LATENCY(RDL), .INIT_CYCLES(64)
    ) dut (.s_clk(clk), .s_rst(rst), .bus(ifc));

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] mdl [1024];

    typedef struct {
        logic [30:0] wa, ra;
        logic [31:0] d0, d1, e0, e1;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && ifc.s_app_rd_data_valid) begin
            rx_q.push_back(ifc.s_app_rd_data);
            rx_cyc.push_back(cyc);
        end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int widx(input logic [30:0] a, input int k);
        return ((a >> 1) + k) % 1024;
    endfunction

    task automatic mdl_write(input logic [30:0] a, input int k, input logic [31:0] d, input logic [3:0] m);
        logic [3:0] em;
`ifdef MEM_RESP_MASK_EN
        em = m;
`else
        em = m & 4'b0000;
`endif
        for (int b = 0; b < 4; b++)
            if (!em[b]) mdl[widx(a, k)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic push_cmd(input logic [2:0] c, input logic [30:0] a, output int cap);
        ifc.s_app_af_wren = 1'b1; ifc.s_app_af_cmd = c; ifc.s_app_af_addr = a;
        tick();
        cap = cyc;
        ifc.s_app_af_wren = 1'b0;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] m);
        ifc.s_app_wdf_wren = 1'b1; ifc.s_app_wdf_data = d; ifc.s_app_wdf_mask_data = m;
        tick();
        ifc.s_app_wdf_wren = 1'b0;
    endtask

    task automatic push_wr(input logic [30:0] a, input logic [31:0] d0, input logic [3:0] m0,
                           input logic [31:0] d1, input logic [3:0] m1);
        ifc.s_app_af_wren = 1'b1; ifc.s_app_af_cmd = CMD_WRITE; ifc.s_app_af_addr = a;
        ifc.s_app_wdf_wren = 1'b1; ifc.s_app_wdf_data = d0; ifc.s_app_wdf_mask_data = m0;
        tick();
        ifc.s_app_af_wren = 1'b0;
        ifc.s_app_wdf_data = d1; ifc.s_app_wdf_mask_data = m1;
        tick();
        ifc.s_app_wdf_wren = 1'b0;
        mdl_write(a, 0, d0, m0);
        mdl_write(a, 1, d1, m1);
    endtask

    task automatic throttle();
        int t = 0;
        while ((ifc.s_app_af_afull || ifc.s_app_wdf_afull) && t < 500) begin tick(); t++; end
    endtask

    task automatic wait_beats(input int n, input int lim, input string nm);
        int t = 0;
        while (rx_q.size() < n && t < lim) begin tick(); t++; end
        if (rx_q.size() < n) begin
            total++; bad++;
            $display("FAIL %s: timeout with %0d beats, want %0d", nm, rx_q.size(), n);
        end
    endtask

    task automatic expect_beat(input string nm, input logic [31:0] ed, input int ec);
        logic [31:0] d;
        int          c;
        if (rx_q.size() == 0) return;
        d = rx_q.pop_front();
        c = rx_cyc.pop_front();
        chk({nm, "_data"}, d, ed);
        if (ec >= 0) chk({nm, "_cycle"}, c, ec);
    endtask

    task automatic measure_init(input int push_at, output int rise);
        rise = -1;
        for (int k = 1; k <= 200 && rise < 0; k++) begin
            if (k == push_at) begin
                ifc.s_app_af_wren = 1'b1; ifc.s_app_af_cmd = CMD_READ; ifc.s_app_af_addr = '0;
            end
            tick();
            ifc.s_app_af_wren = 1'b0;
            if (ifc.s_phy_init_done) rise = k;
        end
    endtask

    initial begin
        vec_t        tbl[6];
        int          cap, rise;
        logic [30:0] a;
        logic [31:0] x, y;

        tbl[0] = '{31'd0,          31'd0,    32'h1111_0000, 32'h3333_2222, 32'h1111_0000, 32'h3333_2222};
        tbl[1] = '{31'd4,          31'd4,    32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        tbl[2] = '{31'd2046,       31'd2046, 32'h0123_4567, 32'h89AB_CDEF, 32'h0123_4567, 32'h89AB_CDEF};
        tbl[3] = '{31'd2048,       31'd0,    32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0002};
        tbl[4] = '{31'd1,          31'd0,    32'h55AA_55AA, 32'hAA55_AA55, 32'h55AA_55AA, 32'hAA55_AA55};
        tbl[5] = '{31'h7FFF_FFFE,  31'd2046, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0};

        ifc.s_app_af_wren = 1'b0; ifc.s_app_af_cmd = '0; ifc.s_app_af_addr = '0;
        ifc.s_app_wdf_wren = 1'b0; ifc.s_app_wdf_data = '0; ifc.s_app_wdf_mask_data = '0;

        // Reset state, init timing, pre-init push ignored
        rst = 1'b1;
        tick(3);
        chk("reset_outputs", {ifc.s_phy_init_done, ifc.s_app_af_afull, ifc.s_app_wdf_afull,
                              ifc.s_app_rd_data_valid, ifc.s_err, ifc.s_app_rd_data}, 64'd0);
        rst = 1'b0;
        measure_init(10, rise);
        chk("init_rise_cycle", rise, 64);
        tick(20);
        chk("early_push_no_beats", rx_q.size(), 0);
        chk("early_push_no_err", ifc.s_err, 3'b000);

        // Vector table: write then read, data and first-beat latency
        for (int i = 0; i < 6; i++) begin
            push_wr(tbl[i].wa, tbl[i].d0, 4'h0, tbl[i].d1, 4'h0);
            tick(8);
            push_cmd(CMD_READ, tbl[i].ra, cap);
            wait_beats(2, 50, $sformatf("vec%0d", i));
            expect_beat($sformatf("vec%0d_b0", i), tbl[i].e0, cap + 1 + RDL);
            expect_beat($sformatf("vec%0d_b1", i), tbl[i].e1, cap + 2 + RDL);
        end

        // Write whose data arrives late holds the following read
        push_cmd(CMD_WRITE, 31'd8, cap);
        push_cmd(CMD_READ, 31'd8, cap);
        tick(20);
        chk("stalled_write_blocks_read", rx_q.size(), 0);
        push_beat(32'h7766_5544, 4'h0);
        push_beat(32'h3322_1100, 4'h0);
        wait_beats(2, 50, "late_data");
        expect_beat("late_b0", 32'h7766_5544, -1);
        expect_beat("late_b1", 32'h3322_1100, -1);

        // Random traffic against the word-array model
        for (int i = 0; i < 32; i++) begin
            throttle();
            push_wr(31'(4 * i), $urandom, 4'h0, $urandom, 4'h0);
        end
        for (int i = 0; i < 80; i++) begin
            a = 31'($urandom_range(0, 124));
            throttle();
            if ($urandom_range(0, 1) == 1) begin
                push_wr(a, $urandom, 4'($urandom), $urandom, 4'($urandom));
            end else begin
                push_cmd(CMD_READ, a, cap);
                exp_q.push_back(mdl[widx(a, 0)]);
                exp_q.push_back(mdl[widx(a, 1)]);
            end
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
        end
        wait_beats(exp_q.size(), 3000, "rand_drain");
        while (exp_q.size() > 0 && rx_q.size() > 0) expect_beat("rand_beat", exp_q.pop_front(), -1);
        exp_q.delete();
        chk("rand_no_err", ifc.s_err, 3'b000);

        // Command FIFO fill behind a stalled write, afull threshold, overflow
        tick(10);
        x = 32'hA5A5_0001; y = 32'h5A5A_0002;
        push_cmd(CMD_WRITE, 31'd200, cap);
        mdl_write(31'd200, 0, x, 4'h0);
        mdl_write(31'd200, 1, y, 4'h0);
        tick();
        chk("afull_1", ifc.s_app_af_afull, 1'b0);
        for (int i = 2; i <= 16; i++) begin
            a = (i % 2 == 1) ? 31'd200 : 31'(4 * i);
            push_cmd(CMD_READ, a, cap);
            exp_q.push_back(mdl[widx(a, 0)]);
            exp_q.push_back(mdl[widx(a, 1)]);
            tick();
            chk($sformatf("afull_%0d", i), ifc.s_app_af_afull, i >= 12);
        end
        push_cmd(CMD_READ, 31'd0, cap);
        tick();
        chk("af_overflow_err", ifc.s_err, 3'b001);
        push_beat(x, 4'h0);
        push_beat(y, 4'h0);
        wait_beats(30, 500, "fill_drain");
        while (exp_q.size() > 0 && rx_q.size() > 0) expect_beat("fill_beat", exp_q.pop_front(), -1);
        tick(20);
        chk("fill_no_extra_beats", rx_q.size(), 0);

        // Illegal command, then a read still completes; byte mask behaviour
        push_cmd(3'b101, 31'd0, cap);
        tick(3);
        chk("illegal_err", ifc.s_err, 3'b101);
        push_cmd(CMD_READ, 31'd200, cap);
        wait_beats(2, 50, "after_illegal");
        expect_beat("after_ill_b0", x, -1);
        expect_beat("after_ill_b1", y, -1);
        push_wr(31'd300, 32'hAABB_CCDD, 4'h0, 32'h1234_5678, 4'h0);
        push_wr(31'd300, 32'h0000_0000, 4'b1010, 32'h0000_0000, 4'b0000);
        tick(8);
        push_cmd(CMD_READ, 31'd300, cap);
        wait_beats(2, 50, "mask");
`ifdef MEM_RESP_MASK_EN
        expect_beat("mask_b0", 32'hAA00_CC00, -1);
`else
        expect_beat("mask_b0", 32'h0000_0000, -1);
`endif
        expect_beat("mask_b1", 32'h0000_0000, -1);

        // Reset in the middle of a read burst
        push_cmd(CMD_READ, 31'd200, cap);
        wait_beats(1, 50, "burst_before_reset");
        rst = 1'b1;
        #1;
        chk("reset_mid_burst_outputs", {ifc.s_app_rd_data_valid, ifc.s_phy_init_done, ifc.s_err}, 64'd0);
        rx_q.delete();
        rx_cyc.delete();
        tick(2);
        rst = 1'b0;
        measure_init(0, rise);
        chk("reinit_rise_cycle", rise, 64);
        tick(10);
        chk("no_stale_beats", rx_q.size(), 0);
        push_cmd(CMD_READ, 31'd200, cap);
        wait_beats(2, 50, "ram_kept");
        expect_beat("ram_kept_b0", x, cap + 1 + RDL);
        expect_beat("ram_kept_b1", y, cap + 2 + RDL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
